alu_op_sequencer: RTL and testbench

ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

---
 rtl/alu_pkg.sv | 13 +
 rtl/alu_op_sequencer.sv | 114 +++++++++++
 tb/tb_alu_op_sequencer.sv | 328 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU operand sequencer: datapath widths and FSM state encoding.
package alu_pkg;

  localparam int DATA_W = 16;
  localparam int OP_W   = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_HOLD = 2'd2
  } seq_state_t;

endpackage

// File: rtl/alu_op_sequencer.sv
// ALU operand sequencer: registers one command at a time toward an external
// combinational ALU, captures its result one cycle later and holds it until
// the consumer takes it. A running accumulator (last result) can replace
// operand A.
//
// Optional build macro: ALU_SEQ_FLAGS_EN adds registered zero/negative result
// flags. Without it, out_zero and out_neg are constant 0 and no flag
// registers exist.
//
//   state | meaning
//   IDLE  | no command in flight, ready for a new one
//   EXEC  | operands presented to the ALU, result captured at end of cycle
//   HOLD  | result valid, waiting for out_ready (may accept the next command)
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter logic [DATA_W-1:0] ACC_INIT = 16'h0000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic [OP_W-1:0]   in_op,
  input  logic              in_acc,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_c,
  input  logic [DATA_W-1:0] alu_y,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic              out_zero,
  output logic              out_neg
);

  seq_state_t        state;
  logic [DATA_W-1:0] acc;
  logic              accept;
  logic [DATA_W-1:0] operand_a;

`ifdef ALU_SEQ_FLAGS_EN
  logic zero_q;
  logic neg_q;
  assign out_zero = zero_q;
  assign out_neg  = neg_q;
`else
  assign out_zero = 1'b0;
  assign out_neg  = 1'b0;
`endif

  // Ready in IDLE, or in HOLD when the held result is being retired this cycle.
  assign in_ready  = (state == ST_IDLE) || ((state == ST_HOLD) && out_ready);
  assign accept    = in_valid && in_ready;
  // acc is already updated by the preceding EXEC, so back-to-back chaining sees the newest result.
  assign operand_a = in_acc ? acc : in_a;

  // Sequencer FSM with registered ALU operands, result, flags and accumulator.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      out_valid  <= 1'b0;
      out_result <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_c      <= '0;
      acc        <= ACC_INIT;
`ifdef ALU_SEQ_FLAGS_EN
      zero_q     <= 1'b0;
      neg_q      <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            alu_a <= operand_a;
            alu_b <= in_b;
            alu_c <= in_op;
            state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          out_result <= alu_y;
          acc        <= alu_y;
          out_valid  <= 1'b1;
`ifdef ALU_SEQ_FLAGS_EN
          zero_q     <= (alu_y == '0);
          neg_q      <= alu_y[DATA_W-1];
`endif
          state      <= ST_HOLD;
        end
        ST_HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (in_valid) begin
              alu_a <= operand_a;
              alu_b <= in_b;
              alu_c <= in_op;
              state <= ST_EXEC;
            end else begin
              state <= ST_IDLE;
            end
          end
        end
        default: begin
          state     <= ST_IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer. The external ALU is a stub
// computing alu_a + alu_b. Expected results come from a transaction-level
// model: each accepted command yields (acc or a) + b, which also becomes the
// new accumulator. Build with ALU_SEQ_FLAGS_EN defined to expect live flags.
module tb_alu_op_sequencer;

  localparam logic [15:0] ACC_INIT_T = 16'h1234;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic [2:0]  in_op;
  logic        in_acc;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [2:0]  alu_c;
  logic [15:0] alu_y;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_result;
  logic        out_zero;
  logic        out_neg;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [15:0] opa;
    logic [15:0] b;
    logic [2:0]  op;
    logic [15:0] res;
  } exp_t;

  exp_t        q[$];
  logic [15:0] model_acc;
  logic        m_exec;
  logic        m_have;

  alu_op_sequencer #(.ACC_INIT(ACC_INIT_T)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_acc(in_acc),
    .alu_a(alu_a), .alu_b(alu_b), .alu_c(alu_c), .alu_y(alu_y),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_zero(out_zero), .out_neg(out_neg)
  );

  assign alu_y = alu_a + alu_b;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic exp_zero(input logic [15:0] r);
`ifdef ALU_SEQ_FLAGS_EN
    return (r == 16'h0000);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic exp_neg(input logic [15:0] r);
`ifdef ALU_SEQ_FLAGS_EN
    return r[15];
`else
    return 1'b0;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One isolated command from IDLE with out_ready=1; checks latency, result, operands, flags.
  task automatic run_one(input logic [15:0] a, input logic [15:0] b, input logic [2:0] op,
                         input logic use_acc, input string name);
    logic [15:0] opa;
    logic [15:0] res;
    opa = use_acc ? model_acc : a;
    res = opa + b;
    model_acc = res;
    in_valid = 1'b1; in_a = a; in_b = b; in_op = op; in_acc = use_acc; out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL %s_ready_idle got %b want 1", name, in_ready);
    end
    tick();
    in_valid = 1'b0; in_a = 16'($urandom); in_b = 16'($urandom); in_acc = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      errors++; $display("FAIL %s_exec got valid=%b ready=%b want 0 0", name, out_valid, in_ready);
    end
    tick();
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_result !== res) begin
      errors++; $display("FAIL %s_result got valid=%b result=%h want 1 %h", name, out_valid, out_result, res);
    end
    checks++;
    if (alu_a !== opa || alu_b !== b || alu_c !== op) begin
      errors++; $display("FAIL %s_operands got a=%h b=%h c=%h want %h %h %h", name, alu_a, alu_b, alu_c, opa, b, op);
    end
    checks++;
    if (out_zero !== exp_zero(res) || out_neg !== exp_neg(res)) begin
      errors++; $display("FAIL %s_flags got z=%b n=%b want %b %b", name, out_zero, out_neg, exp_zero(res), exp_neg(res));
    end
    tick();
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL %s_retire got valid=%b want 0", name, out_valid);
    end
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_op = '0; in_acc = 1'b0; out_ready = 1'b0;
    model_acc = ACC_INIT_T;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || out_result !== 16'h0 || out_zero !== 1'b0 || out_neg !== 1'b0) begin
      errors++; $display("FAIL reset_outputs got v=%b r=%h z=%b n=%b want 0 0 0 0", out_valid, out_result, out_zero, out_neg);
    end
    checks++;
    if (alu_a !== 16'h0 || alu_b !== 16'h0 || alu_c !== 3'h0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_alu got a=%h b=%h c=%h rdy=%b want 0 0 0 1", alu_a, alu_b, alu_c, in_ready);
    end
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_acc_init();
    run_one(16'hdead, 16'h0011, 3'd5, 1'b1, "acc_init");
  endtask

  task automatic test_basic();
    run_one(16'h0003, 16'h0004, 3'b000, 1'b0, "basic");
  endtask

  task automatic test_acc();
    run_one(16'hbeef, 16'h0001, 3'b010, 1'b1, "acc_chain");
    run_one(16'h4444, 16'h0100, 3'b001, 1'b1, "acc_chain2");
  endtask

  task automatic test_hold();
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] res;
    a = 16'($urandom); b = 16'($urandom);
    res = a + b; model_acc = res;
    out_ready = 1'b0;
    in_valid = 1'b1; in_a = a; in_b = b; in_op = 3'd6; in_acc = 1'b0;
    tick();
    in_valid = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_a = 16'($urandom); in_b = 16'($urandom); in_op = 3'd1; in_acc = 1'($urandom);
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_result !== res || in_ready !== 1'b0) begin
        errors++; $display("FAIL hold_%0d got v=%b r=%h rdy=%b want 1 %h 0", i, out_valid, out_result, in_ready, res);
      end
      checks++;
      if (alu_a !== a || alu_b !== b || alu_c !== 3'd6) begin
        errors++; $display("FAIL hold_ops_%0d got a=%h b=%h c=%h want %h %h 6", i, alu_a, alu_b, alu_c, a, b);
      end
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL hold_release got v=%b rdy=%b want 0 1", out_valid, in_ready);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [15:0] res[4];
    logic [15:0] a;
    logic [15:0] b;
    logic        use_acc;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a = 16'($urandom); b = 16'($urandom); use_acc = (i == 2);
      in_valid = 1'b1; in_a = a; in_b = b; in_op = 3'(i); in_acc = use_acc;
      res[i] = (use_acc ? model_acc : a) + b;
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1) begin
        errors++; $display("FAIL b2b_ready_%0d got %b want 1", i, in_ready);
      end
      if (i > 0) begin
        checks++;
        if (out_valid !== 1'b1 || out_result !== res[i-1]) begin
          errors++; $display("FAIL b2b_result_%0d got v=%b r=%h want 1 %h", i - 1, out_valid, out_result, res[i-1]);
        end
      end
      model_acc = res[i];
      tick();
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
        errors++; $display("FAIL b2b_exec_%0d got v=%b rdy=%b want 0 0", i, out_valid, in_ready);
      end
      tick();
    end
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_result !== res[3]) begin
      errors++; $display("FAIL b2b_result_3 got v=%b r=%h want 1 %h", out_valid, out_result, res[3]);
    end
    tick();
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL b2b_idle got v=%b want 0", out_valid);
    end
    tick();
  endtask

  task automatic test_flags();
    run_one(16'hffff, 16'h0001, 3'd0, 1'b0, "flags_zero");
    run_one(16'h8000, 16'h0000, 3'd0, 1'b0, "flags_neg");
  endtask

  task automatic test_reset_exec();
    out_ready = 1'b1;
    in_valid = 1'b1; in_a = 16'h1111; in_b = 16'h2222; in_op = 3'd3; in_acc = 1'b0;
    tick();
    in_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL rst_exec_async got v=%b rdy=%b want 0 1", out_valid, in_ready);
    end
    @(posedge clk);
    #1 reset = 1'b0;
    model_acc = ACC_INIT_T;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL rst_exec_release got v=%b rdy=%b want 0 1", out_valid, in_ready);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
        errors++; $display("FAIL rst_exec_quiet_%0d got v=%b want 0", i, out_valid);
      end
    end
    tick();
    run_one(16'h0f0f, 16'h0005, 3'd7, 1'b1, "rst_exec_acc");
  endtask

  // One cycle of the random scenario: check against the transaction model, then advance it.
  task automatic rand_cycle(input logic v, input logic rdy);
    logic exp_rdy;
    logic acc_now;
    exp_t e;
    in_valid = v; in_a = 16'($urandom); in_b = 16'($urandom); in_op = 3'($urandom);
    in_acc = ($urandom_range(0, 2) == 0); out_ready = rdy;
    @(negedge clk);
    exp_rdy = !m_exec && (!m_have || rdy);
    checks++;
    if (in_ready !== exp_rdy || out_valid !== m_have) begin
      errors++; $display("FAIL rand_handshake got rdy=%b v=%b want %b %b", in_ready, out_valid, exp_rdy, m_have);
    end
    if (m_have) begin
      checks++;
      if (out_result !== q[0].res || alu_a !== q[0].opa || alu_b !== q[0].b || alu_c !== q[0].op
          || out_zero !== exp_zero(q[0].res) || out_neg !== exp_neg(q[0].res)) begin
        errors++; $display("FAIL rand_result got r=%h a=%h b=%h c=%h z=%b n=%b want %h %h %h %h",
                           out_result, alu_a, alu_b, alu_c, out_zero, out_neg, q[0].res, q[0].opa, q[0].b, q[0].op);
      end
    end
    acc_now = v && exp_rdy;
    if (m_have && rdy && q.size() > 0) void'(q.pop_front());
    if (acc_now) begin
      e.opa = in_acc ? model_acc : in_a;
      e.b   = in_b;
      e.op  = in_op;
      e.res = e.opa + in_b;
      model_acc = e.res;
      q.push_back(e);
    end
    m_have = m_exec || (m_have && !rdy);
    m_exec = acc_now;
    tick();
  endtask

  task automatic test_random();
    m_exec = 1'b0; m_have = 1'b0; q.delete();
    for (int c = 0; c < 400; c++)
      rand_cycle(1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0));
    for (int c = 0; c < 4; c++)
      rand_cycle(1'b0, 1'b1);
    checks++;
    if (q.size() != 0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL rand_drain got pending=%0d v=%b want 0 0", q.size(), out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_acc_init();
    test_basic();
    test_acc();
    test_hold();
    test_back_to_back();
    test_flags();
    test_reset_exec();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
